// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequences one 4-bit add slice over NIBBLES cycles to add two W-bit operands.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carry
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_next;
    logic [W-1:0]   a_reg, b_reg;
    logic [IW-1:0]  idx;
    logic           cin;
    logic           last;
    logic [4:0]     slice;

    assign busy = (state == RUN);

    always_comb begin
        last       = (idx == IW'(NIBBLES - 1));
        slice      = {1'b0, a_reg[{idx, 2'b00} +: 4]} + {1'b0, b_reg[{idx, 2'b00} +: 4]} + {4'b0, cin};
        state_next = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Unprocessed sum nibbles keep their previous values while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            cin   <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_reg <= a;
                b_reg <= b;
                idx   <= '0;
                cin   <= 1'b0;
            end else if (state == RUN) begin
                sum[{idx, 2'b00} +: 4] <= slice[3:0];
                cin <= slice[4];
                idx <= idx + 1'b1;
                if (last) begin
                    carry <= slice[4];
                    done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed self-checking bench for adder_seq_ctrl with NIBBLES=4.
module tb_adder_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, carry;
    logic [15:0] sum;
    int          n_checks = 0;
    int          n_fail = 0;

    adder_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: presents operands with start, returns at the negedge after the accepting edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
    endtask

    // Checks four busy cycles then the done cycle; optionally hammers start while busy.
    task automatic finish_op(input string tag, input logic [15:0] es, input logic ec, input logic hammer);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 16'(busy), 16'h1);
            chk({tag, "_nodone"}, 16'(done), 16'h0);
            if (hammer) begin
                start = 1'b1;
                a = 16'hAAAA;
                b = 16'h5555;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 16'(done), 16'h1);
        chk({tag, "_busy_lo"}, 16'(busy), 16'h0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_carry"}, 16'(carry), 16'(ec));
    endtask

    task automatic idle_hold(input string tag, input logic [15:0] es, input logic ec);
        @(negedge clk);
        chk({tag, "_done_lo"}, 16'(done), 16'h0);
        chk({tag, "_idle"}, 16'(busy), 16'h0);
        chk({tag, "_sum_hold"}, sum, es);
        chk({tag, "_carry_hold"}, 16'(carry), 16'(ec));
    endtask

    initial begin
        // Reset held with start asserted
        start = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        repeat (3) @(negedge clk);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_carry", 16'(carry), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'h0;
        b = 16'h0;
        chk("rst_first_accept", 16'(busy), 16'h1);
        finish_op("basic", 16'h5555, 1'b0, 1'b0);
        idle_hold("basic", 16'h5555, 1'b0);
        repeat (2) @(negedge clk);
        chk("basic_long_hold", sum, 16'h5555);

        // Carry chains
        start_op(16'h0FFF, 16'h0001);
        finish_op("chain1", 16'h1000, 1'b0, 1'b0);
        idle_hold("chain1", 16'h1000, 1'b0);
        start_op(16'hFFFF, 16'h0001);
        finish_op("chain2", 16'h0000, 1'b1, 1'b0);
        idle_hold("chain2", 16'h0000, 1'b1);

        // Start held high throughout an operation is ignored
        start_op(16'h0102, 16'h0304);
        finish_op("ignore", 16'h0406, 1'b0, 1'b1);
        idle_hold("ignore", 16'h0406, 1'b0);

        // Back-to-back: second start presented in the done cycle
        start_op(16'h9999, 16'h1111);
        finish_op("b2b1", 16'hAAAA, 1'b0, 1'b0);
        start_op(16'hF00F, 16'h1FF1);
        chk("b2b_accept_done_lo", 16'(done), 16'h0);
        finish_op("b2b2", 16'h1000, 1'b1, 1'b0);
        idle_hold("b2b2", 16'h1000, 1'b1);

        // Asynchronous reset two cycles after start
        start_op(16'h1111, 16'h2222);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_done", 16'(done), 16'h0);
        chk("mid_rst_sum", sum, 16'h0000);
        chk("mid_rst_carry", 16'(carry), 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 16'(done), 16'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'h8000, 16'h8000);
        finish_op("post_rst", 16'h0000, 1'b1, 1'b0);
        idle_hold("post_rst", 16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
